// File: rtl/clock_display_pkg.sv
// Shared constants for the 6-digit multiplexed clock display.
// Latency: n/a (constants only).
// Backpressure: none.
package clock_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // All digit enables released (active low)
  localparam logic [5:0] AN_OFF = 6'b111111;

  // Scan slot order, rightmost digit first
  localparam logic [2:0] SLOT_S0 = 3'd0;
  localparam logic [2:0] SLOT_S1 = 3'd1;
  localparam logic [2:0] SLOT_M0 = 3'd2;
  localparam logic [2:0] SLOT_M1 = 3'd3;
  localparam logic [2:0] SLOT_H0 = 3'd4;
  localparam logic [2:0] SLOT_H1 = 3'd5;

  // Slots whose decimal point forms the HH:MM:SS colons
  localparam logic [5:0] COLON_SLOTS = 6'b010100;

endpackage

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern; codes 10-15 show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup, invalid BCD falls through to the dash
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Time-multiplexed HH:MM:SS 7-segment driver with per-frame snapshot and alarm blink.
// Latency: an/seg/dp registered, 1 clk behind the scan state.
// Backpressure: none; inputs are sampled once per frame.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2,
  parameter int BLANK_LEAD   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       Alarm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_off;
  logic             tick;
  logic             frame_end;
  logic [1:0]       snap_h1;
  logic [3:0]       snap_h0, snap_m1, snap_m0, snap_s1, snap_s0;
  logic [3:0]       slot_digit;
  logic [6:0]       slot_seg;
  logic             lead_blank;

  assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = tick && (digit_idx == SLOT_H1);

  // Slot divider and digit rotation
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_idx <= SLOT_S0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) digit_idx <= (digit_idx == SLOT_H1) ? SLOT_S0 : digit_idx + 3'd1;
    end
  end

  // Capture all digits together at frame boundaries so a frame never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_h1 <= '0;
      snap_h0 <= '0;
      snap_m1 <= '0;
      snap_m0 <= '0;
      snap_s1 <= '0;
      snap_s0 <= '0;
    end else if (frame_end) begin
      snap_h1 <= H_in1;
      snap_h0 <= H_in0;
      snap_m1 <= M_in1;
      snap_m0 <= M_in0;
      snap_s1 <= S_in1;
      snap_s0 <= S_in0;
    end
  end

  // Alarm blink: toggle visibility every BLINK_FRAMES frames, clear when alarm drops
  always_ff @(posedge clk) begin
    if (reset || !Alarm) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // Pick the snapshot digit for the active slot
  always_comb begin
    slot_digit = 4'd0;
    case (digit_idx)
      SLOT_S0: slot_digit = snap_s0;
      SLOT_S1: slot_digit = snap_s1;
      SLOT_M0: slot_digit = snap_m0;
      SLOT_M1: slot_digit = snap_m1;
      SLOT_H0: slot_digit = snap_h0;
      SLOT_H1: slot_digit = {2'b00, snap_h1};
      default: slot_digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (slot_digit),
    .seg (slot_seg)
  );

  assign lead_blank = (BLANK_LEAD != 0) && (digit_idx == SLOT_H1) && (snap_h1 == 2'd0);

  // Registered display drive; blank phase and leading-zero suppression force all-off
  always_ff @(posedge clk) begin
    if (reset || blink_off || lead_blank) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(6'b000001 << digit_idx);
      seg <= slot_seg;
      dp  <= ~COLON_SLOTS[digit_idx];
    end
  end

endmodule
